// File: rtl/mem_pipe_rw.sv
// ----------------------------------------------------------------------------
// mem_pipe_rw
// Single-port synchronous memory with byte-enable writes, a read pipeline of
// RD_LATENCY stages, a ready/valid style handshake and out-of-range error
// reporting.
//
// Parameters
//   ADDR_WIDTH  address bus width
//   DATA_WIDTH  data width in bits (multiple of 8)
//   DEPTH       number of words, 1..2**ADDR_WIDTH
//   RD_LATENCY  cycles from read accept to valid, 1..4
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-low reset
//   addr        word address
//   write_data  write data
//   byte_en     write byte strobes, bit i covers bits [8i+7:8i]
//   wren        write request
//   rden        read request
//   ready       request can be accepted this cycle
//   read_data   read result, qualified by valid (holds when valid=0)
//   valid       one-cycle pulse per accepted read
//   wr_ack      one-cycle pulse, the cycle after a write accept
//   err         address was >= DEPTH; qualifies valid / wr_ack
//
// Optional feature
//   MEM_CLEAR_EN  when defined, the INIT state walks every word and writes
//                 zero (one word per cycle) before entering RUN.
// ----------------------------------------------------------------------------
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RESET | reset asserted; no requests accepted, outputs cleared
// ST_INIT  | first cycle(s) after release; memory clear walk if enabled
// ST_RUN   | normal operation, ready=1
//
module mem_pipe_rw #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int RD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] byte_en,
   input  logic                    wren,
   input  logic                    rden,
   output logic                    ready,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    valid,
   output logic                    wr_ack,
   output logic                    err
);

   localparam int                  LP_BYTES = DATA_WIDTH / 8;
   localparam int                  LP_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_RESET,
      ST_INIT,
      ST_RUN
   } state_t;

   state_t                r_state;
   state_t                w_next;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [LP_IDX_W-1:0]   w_idx;
   logic                  w_in_range;
   logic                  w_accept;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_clr_done;
   logic [DATA_WIDTH-1:0] w_mem_word;
   logic [DATA_WIDTH-1:0] w_merged;
   logic [DATA_WIDTH-1:0] w_rd_word;

   logic                  r_wr_ack;
   logic                  r_wr_err;
   logic [RD_LATENCY-1:0] r_vld;
   logic [RD_LATENCY-1:0] r_perr;
   logic [DATA_WIDTH-1:0] r_pdata [RD_LATENCY];

   // Upper address bits beyond the index width are only ever non-zero for
   // out-of-range addresses, which never touch the array.
   assign w_idx      = addr[LP_IDX_W-1:0];
   assign w_in_range = ({1'b0, addr} < LP_DEPTH);

   // A request seen on the same edge that samples reset low is discarded.
   assign w_accept   = ready & reset & (wren | rden);
   assign w_wr_acc   = w_accept & wren;
   assign w_rd_acc   = w_accept & rden;

`ifdef MEM_CLEAR_EN
   logic [LP_IDX_W-1:0] r_clr_idx;

   assign w_clr_done = (r_clr_idx == LP_IDX_W'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_clr_idx <= '0;
      end else if (r_state == ST_INIT && !w_clr_done) begin
         r_clr_idx <= r_clr_idx + LP_IDX_W'(1);
      end
   end
`else
   assign w_clr_done = 1'b1;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_RESET;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      ready  = 1'b0;
      case (r_state)
         ST_RESET: w_next = ST_INIT;
         ST_INIT:  if (w_clr_done) w_next = ST_RUN;
         ST_RUN:   ready = 1'b1;
         default:  w_next = ST_RESET;
      endcase
   end

   // ------------------------------------------------------- array access
   // Write-first merge: a simultaneous read sees the post-write word.
   always_comb begin
      w_mem_word = r_mem[w_idx];
      w_merged   = w_mem_word;
      for (int i = 0; i < LP_BYTES; i++) begin
         if (wren && byte_en[i]) begin
            w_merged[8*i +: 8] = write_data[8*i +: 8];
         end
      end
      w_rd_word = w_in_range ? w_merged : '0;
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc && w_in_range) begin
         r_mem[w_idx] <= w_merged;
      end
`ifdef MEM_CLEAR_EN
      else if (reset && r_state == ST_INIT) begin
         r_mem[r_clr_idx] <= '0;
      end
`endif
   end

   // ----------------------------------------------------- write response
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ack <= 1'b0;
         r_wr_err <= 1'b0;
      end else begin
         r_wr_ack <= w_wr_acc;
         r_wr_err <= w_wr_acc & ~w_in_range;
      end
   end

   // ------------------------------------------------------ read pipeline
   // Data stages only advance behind a valid token, so the last stage keeps
   // the previous result through bubbles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_vld  <= '0;
         r_perr <= '0;
         for (int k = 0; k < RD_LATENCY; k++) begin
            r_pdata[k] <= '0;
         end
      end else begin
         r_vld[0]  <= w_rd_acc;
         r_perr[0] <= w_rd_acc & ~w_in_range;
         if (w_rd_acc) begin
            r_pdata[0] <= w_rd_word;
         end
         for (int k = 1; k < RD_LATENCY; k++) begin
            r_vld[k]  <= r_vld[k-1];
            r_perr[k] <= r_perr[k-1];
            if (r_vld[k-1]) begin
               r_pdata[k] <= r_pdata[k-1];
            end
         end
      end
   end

   assign valid     = r_vld[RD_LATENCY-1];
   assign read_data = r_pdata[RD_LATENCY-1];
   assign wr_ack    = r_wr_ack;
   assign err       = (r_vld[RD_LATENCY-1] & r_perr[RD_LATENCY-1]) |
                      (r_wr_ack & r_wr_err);

endmodule
